// File: rtl/leaky_relu_pkg.sv
// Shared types for the leaky_relu activation arbiter: FSM states, in-flight
// beat tags and the owner one-hot decode.
package leaky_relu_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_WIDTH_DEF = 8;
    localparam int MAX_REQ        = 8;
    localparam int OWNER_W        = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               last;
    } act_tag_t;

    function automatic logic [MAX_REQ-1:0] owner_onehot(input logic [OWNER_W-1:0] owner);
        owner_onehot = 8'b0000_0001 << owner;
    endfunction

endpackage

// File: rtl/leaky_relu_arbiter_if.sv
// Bundle of requester, activation-unit and response signals around the arbiter.
interface leaky_relu_arbiter_if
    import leaky_relu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         act_x;
    logic                          act_valid;
    logic [DATA_WIDTH-1:0]         act_y;
    logic                          act_valid_out;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_last;
    logic                          busy;
    logic                          err_unexp;

    modport master (
        output req_valid, req_data, req_last, act_y, act_valid_out,
        input  req_ready, act_x, act_valid, rsp_data, rsp_valid, rsp_last, busy, err_unexp
    );

    modport slave (
        input  req_valid, req_data, req_last, act_y, act_valid_out,
        output req_ready, act_x, act_valid, rsp_data, rsp_valid, rsp_last, busy, err_unexp
    );
endinterface

// File: rtl/leaky_relu_arbiter_act_tag_pipe.sv
// Shift register carrying beat ownership tags alongside the activation unit's
// pipeline so the last slot lines up with the unit's result strobe.
module act_tag_pipe
    import leaky_relu_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  act_tag_t tag_in,
    output act_tag_t tag_out,
    output logic     any_valid
);
    act_tag_t pipe_r [LATENCY];

    // advance every tag one slot per cycle; reset drops all in-flight tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[LATENCY-1];

    // any slot holding a live beat
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | pipe_r[i].valid;
        end
    end
endmodule

// File: rtl/leaky_relu_arbiter.sv
// Round-robin burst arbiter sharing one leaky_relu unit among NUM_REQ streams,
// routing each result back to its owner as a one-hot response.
module leaky_relu_arbiter
    import leaky_relu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int LATENCY    = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    leaky_relu_arbiter_if.slave bus
);
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || LATENCY < 1 || LATENCY > 8 ||
        FRAC_WIDTH >= DATA_WIDTH) begin : g_param_check
        $error("leaky_relu_arbiter: parameter out of range");
    end

    arb_state_e            state_r, state_nxt_s;
    logic [OWNER_W-1:0]    owner_r, owner_nxt_s, rr_ptr_r, rr_ptr_nxt_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic                  hs_s, hs_last_s, found_s, take_s;
    logic [DATA_WIDTH-1:0] sel_data_s, act_x_r, rsp_data_r;
    logic [3:0]            cand_s, wrap_s;
    logic                  act_valid_r, rsp_last_r, busy_r, err_r, pipe_any_s;
    logic [NUM_REQ-1:0]    rsp_valid_r;
    act_tag_t              issue_tag_r, tag_out_s;

    assign ready_s = (state_r == ST_LOCK) ? NUM_REQ'(owner_onehot(owner_r)) : '0;
    assign wrap_s  = {1'b0, owner_r} + 4'd1;

    // owner's beat: handshake, last flag and AND-OR data mux
    always_comb begin
        hs_s       = |(bus.req_valid & ready_s);
        hs_last_s  = |(bus.req_last & ready_s);
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = sel_data_s |
                         (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{ready_s[i]}});
        end
    end

    // next-state: round-robin pick in IDLE, release on the final handshake
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        found_s      = 1'b0;
        take_s       = 1'b0;
        cand_s       = 4'd0;
        case (state_r)
            ST_IDLE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand_s      = {1'b0, rr_ptr_r} + 4'(k);
                    cand_s      = (cand_s >= 4'(NUM_REQ)) ? cand_s - 4'(NUM_REQ) : cand_s;
                    take_s      = !found_s && (|(bus.req_valid & (NUM_REQ'(1'b1) << cand_s)));
                    owner_nxt_s = take_s ? cand_s[OWNER_W-1:0] : owner_nxt_s;
                    found_s     = found_s | take_s;
                end
                state_nxt_s = found_s ? ST_LOCK : ST_IDLE;
            end
            ST_LOCK: begin
                if (hs_s && hs_last_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = (wrap_s >= 4'(NUM_REQ)) ? 3'd0 : wrap_s[OWNER_W-1:0];
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= 3'd0;
            rr_ptr_r <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // issue accepted beat to the unit together with its ownership tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_r     <= '0;
            act_valid_r <= 1'b0;
            issue_tag_r <= '0;
        end else begin
            act_valid_r <= hs_s;
            issue_tag_r <= '{valid: hs_s, owner: owner_r, last: hs_s & hs_last_s};
            if (hs_s) begin
                act_x_r <= sel_data_s;
            end
        end
    end

    act_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_in   (issue_tag_r),
        .tag_out  (tag_out_s),
        .any_valid(pipe_any_s)
    );

    // route results; a strobe/tag disagreement in either direction is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r  <= '0;
            rsp_valid_r <= '0;
            rsp_last_r  <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= (bus.act_valid_out && tag_out_s.valid) ?
                           NUM_REQ'(owner_onehot(tag_out_s.owner)) : '0;
            rsp_last_r  <= bus.act_valid_out & tag_out_s.valid & tag_out_s.last;
            err_r       <= err_r | (bus.act_valid_out ^ tag_out_s.valid);
            busy_r      <= (state_r == ST_LOCK) | issue_tag_r.valid | pipe_any_s;
            if (bus.act_valid_out) begin
                rsp_data_r <= bus.act_y;
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.act_x     = act_x_r;
    assign bus.act_valid = act_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.busy      = busy_r;
    assign bus.err_unexp = err_r;
endmodule

// File: tb/tb_leaky_relu_arbiter.sv
// Bench: two arbiters (LATENCY 1 and 4) with behavioural activation units,
// checked against a transaction-level round-robin model.
module tb_leaky_relu_arbiter;
    import leaky_relu_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic stray;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    leaky_relu_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
    leaky_relu_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus_d ();

    leaky_relu_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FRAC_WIDTH(8), .LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    leaky_relu_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FRAC_WIDTH(8), .LATENCY(4)) u_deep (
        .clk(clk), .rst_n(rst_n), .bus(bus_d));

    // leaky ReLU with slope 1/128 on negative samples (Q8.8)
    function automatic logic [DW-1:0] lrelu(input logic [DW-1:0] x);
        logic signed [DW-1:0] s;
        s = x;
        return (s < 0) ? 16'(s >>> 7) : x;
    endfunction

    logic          u_v;
    logic [DW-1:0] u_y;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_v <= 1'b0;
            u_y <= '0;
        end else begin
            u_v <= bus.act_valid;
            u_y <= lrelu(bus.act_x);
        end
    end
    assign bus.act_valid_out = u_v | stray;
    assign bus.act_y         = u_y;

    logic [DW:0] dpipe [4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) dpipe[i] <= '0;
        end else begin
            dpipe[0] <= {bus_d.act_valid, lrelu(bus_d.act_x)};
            for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign bus_d.act_valid_out = dpipe[3][DW];
    assign bus_d.act_y         = dpipe[3][DW-1:0];

    typedef struct {logic [DW-1:0] data; logic last; int gap;} beat_t;
    typedef struct {int owner; logic [DW-1:0] y; logic last; int h;} exp_t;

    beat_t         bq [NR][$];
    exp_t          eq [$];
    exp_t          dq [$];
    logic [NR-1:0] hs_vec;
    int            m_lock, m_ptr;
    logic          prev_locked, prev_hs, err_exp;
    logic [DW-1:0] prev_x;
    int            grants [NR];
    logic          d_locked, d_hs;
    int            d_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int r, input logic [DW-1:0] d, input logic last, input int gap);
        beat_t b;
        b.data = d; b.last = last; b.gap = gap;
        bq[r].push_back(b);
    endtask

    // Reference: a burst owner is fixed until its last beat; the next owner is the
    // first requester at/after the pointer; every result returns LATENCY+2 after accept.
    task automatic model_main();
        logic [DW-1:0] x;
        check("req_ready", bus.req_ready, (m_lock >= 0) ? 32'(1 << m_lock) : 32'd0);
        check("act_valid", bus.act_valid, prev_hs);
        if (prev_hs) check("act_x", bus.act_x, prev_x);
        if (eq.size() > 0) check("busy_inflight", bus.busy, 1);
        else if (!prev_locked) check("busy_idle", bus.busy, 0);
        if (eq.size() > 0 && eq[0].h + 3 == cyc) begin
            check("rsp_valid", bus.rsp_valid, 32'(1 << eq[0].owner));
            check("rsp_data", bus.rsp_data, eq[0].y);
            check("rsp_last", bus.rsp_last, eq[0].last);
            grants[eq[0].owner]++;
            eq.delete(0);
        end else begin
            check("rsp_valid_quiet", bus.rsp_valid, 0);
        end
        check("err_unexp", bus.err_unexp, err_exp);
        prev_locked = (m_lock >= 0);
        prev_hs = 1'b0;
        hs_vec = '0;
        if (m_lock >= 0) begin
            if (bus.req_valid[m_lock]) begin
                x = bus.req_data[m_lock*DW +: DW];
                prev_hs = 1'b1;
                prev_x = x;
                hs_vec[m_lock] = 1'b1;
                eq.push_back('{owner: m_lock, y: lrelu(x), last: bus.req_last[m_lock], h: cyc});
                if (bus.req_last[m_lock]) begin
                    m_ptr = (m_lock + 1) % NR;
                    m_lock = -1;
                end
            end
        end else if (rst_n && |bus.req_valid) begin
            for (int k = 0; k < NR && m_lock < 0; k++) begin
                if (bus.req_valid[(m_ptr + k) % NR]) m_lock = (m_ptr + k) % NR;
            end
        end
        if (stray && rst_n) err_exp = 1'b1;
    endtask

    task automatic model_deep();
        check("d_req_ready", bus_d.req_ready, d_locked ? 32'd1 : 32'd0);
        if (dq.size() > 0 && dq[0].h + 6 == cyc) begin
            check("d_rsp_valid", bus_d.rsp_valid, 32'd1);
            check("d_rsp_data", bus_d.rsp_data, dq[0].y);
            check("d_rsp_last", bus_d.rsp_last, dq[0].last);
            dq.delete(0);
        end else begin
            check("d_rsp_quiet", bus_d.rsp_valid, 0);
        end
        d_hs = 1'b0;
        if (d_locked) begin
            if (bus_d.req_valid[0]) begin
                d_hs = 1'b1;
                dq.push_back('{owner: 0, y: lrelu(bus_d.req_data[DW-1:0]),
                               last: bus_d.req_last[0], h: cyc});
                if (bus_d.req_last[0]) d_locked = 1'b0;
            end
        end else if (rst_n && bus_d.req_valid[0]) begin
            d_locked = 1'b1;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NR; i++) begin
            if (hs_vec[i]) begin
                bq[i].delete(0);
                bus.req_valid[i] = 1'b0;
                bus.req_last[i] = 1'b0;
            end
            if (!bus.req_valid[i] && bq[i].size() > 0) begin
                b = bq[i][0];
                if (b.gap > 0) begin
                    b.gap--;
                    bq[i][0] = b;
                end else begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = b.data;
                    bus.req_last[i] = b.last;
                end
            end
        end
        if (d_hs) begin
            d_left--;
            bus_d.req_data[DW-1:0] = 16'($urandom);
        end
        bus_d.req_valid[0] = (d_left > 0);
        bus_d.req_last[0] = (d_left == 1);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_main();
        model_deep();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            tick();
            done = (eq.size() == 0) && (dq.size() == 0) && (d_left == 0) && (bus.req_valid == '0);
            for (int i = 0; i < NR; i++) done = done && (bq[i].size() == 0);
        end
        check(tag, done, 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) bq[i].delete();
        eq.delete();
        dq.delete();
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus_d.req_valid = '0;
        bus_d.req_last = '0;
        m_lock = -1; m_ptr = 0;
        prev_locked = 1'b0; prev_hs = 1'b0; prev_x = '0;
        hs_vec = '0; d_locked = 1'b0; d_hs = 1'b0; d_left = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        stray = 1'b0;
        err_exp = 1'b0;
        bus_d.req_data = '0;
        for (int i = 0; i < NR; i++) grants[i] = 0;
        clear_model();
        tick();
        tick();
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_act_valid", bus.act_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();

        // single beat from requester 0
        add(0, 16'hFF00, 1'b1, 0);
        drain("single_drain");
        check("single_rsp_data", bus.rsp_data, 16'hFFFE);
        check("single_busy_low", bus.busy, 0);

        // contention between requesters 1 and 2
        for (int r = 1; r <= 2; r++) begin
            add(r, 16'h0100, 1'b0, 0);
            add(r, 16'hFE00, 1'b0, 0);
            add(r, 16'hFC00, 1'b1, 0);
        end
        drain("contention_drain");
        check("contention_last_data", bus.rsp_data, 16'hFFF8);

        // fairness: all four requesters, 1-beat bursts
        for (int i = 0; i < NR; i++) grants[i] = 0;
        for (int n = 0; n < 4; n++)
            for (int r = 0; r < NR; r++) add(r, 16'($urandom), 1'b1, 0);
        drain("fair_drain");
        for (int r = 0; r < NR; r++) check("fair_grants", grants[r], 4);

        // requester 3 burst with gaps while requester 0 waits
        add(3, 16'h1234, 1'b0, 0);
        add(3, 16'h8765, 1'b0, 2);
        add(3, 16'h00FF, 1'b0, 2);
        add(3, 16'hC000, 1'b1, 2);
        add(0, 16'h7FFF, 1'b1, 0);
        drain("gaps_drain");

        // randomized bursts
        for (int b = 0; b < 24; b++) begin
            int r, n;
            r = $urandom_range(0, NR - 1);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) add(r, 16'($urandom), (j == n - 1), $urandom_range(0, 2));
        end
        drain("random_drain");

        // deep-latency unit, back-to-back beats from requester 0
        bus_d.req_data[DW-1:0] = 16'($urandom);
        d_left = 6;
        drain("deep_drain");
        check("deep_busy_low", bus_d.busy, 0);

        // reset with one beat in flight, then a stray unit strobe
        for (int j = 0; j < 4; j++) add(1, 16'($urandom), (j == 3), 0);
        begin
            bit got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                tick();
                got = prev_hs;
            end
            check("midrst_hs_seen", got, 1);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_act_valid", bus.act_valid, 0);
        check("midrst_act_x", bus.act_x, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        tick();
        check("stray_err_sticky", bus.err_unexp, 1);
        check("stray_rsp_valid", bus.rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
